// File: rtl/shot_resolver_if.sv
// Shot request/result handshake between the game FSM and shot_resolver.
interface shot_resolver_if;
    logic       attack_State;
    logic       new_game;
    logic       fire;
    logic       turn;
    logic [2:0] i_target;
    logic [2:0] j_target;
    logic       busy;
    logic       result_valid;
    logic [1:0] result;

    modport master (
        output attack_State, new_game, fire, turn, i_target, j_target,
        input  busy, result_valid, result
    );
    modport slave (
        input  attack_State, new_game, fire, turn, i_target, j_target,
        output busy, result_valid, result
    );
endinterface

// File: rtl/shot_resolver.sv
// Attack-phase shot resolver: one shot per request, shot maps, hit counters, game over.
// Optional SHOT_RESOLVER_TURN_AUTO_EN: internal turn register (toggles on MISS) replaces the turn port.
module shot_resolver #(
    parameter int N     = 5,
    parameter int CNT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    shot_resolver_if.slave            sr,
    input  logic [CNT_W-1:0]          total_ship_cells,
    input  logic [N-1:0][N-1:0][1:0]  tablero_jugador,
    input  logic [N-1:0][N-1:0][1:0]  tablero_pc,
    output logic [CNT_W-1:0]          player_hits,
    output logic [CNT_W-1:0]          pc_hits,
    output logic                      game_over,
    output logic                      winner,
    output logic                      turn_out,
    output logic [N-1:0][N-1:0]       shots_on_pc,
    output logic [N-1:0][N-1:0]       shots_on_player
);
    typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, OVER} state_t;
    typedef enum logic [1:0] {MISS = 2'b00, HIT = 2'b01, REPEAT = 2'b10, INVALID = 2'b11} code_t;
    typedef struct packed {
        logic       side;
        logic [2:0] i;
        logic [2:0] j;
    } shot_t;

    localparam logic [1:0] BARCO = 2'b01;

    state_t           state;
    shot_t            req;
    logic             turn_q;
    logic             shooter;
    code_t            code;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef SHOT_RESOLVER_TURN_AUTO_EN
    assign shooter = turn_q;
`else
    assign shooter = sr.turn;
`endif
    assign turn_out = turn_q;

    // side 0 = player firing at the PC board, side 1 = PC firing at the player board
    always_comb begin
        code    = MISS;
        cnt     = req.side ? pc_hits : player_hits;
        cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
        if (int'(req.i) >= N || int'(req.j) >= N)
            code = INVALID;
        else if (req.side ? shots_on_player[req.i][req.j] : shots_on_pc[req.i][req.j])
            code = REPEAT;
        else if ((req.side ? tablero_jugador[req.i][req.j] : tablero_pc[req.i][req.j]) == BARCO)
            code = HIT;
    end

    // Resolution is registered on leaving CHECK so result, maps and counters are all
    // visible together during RESOLVE (fire at T, result_valid at T+2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            req             <= '0;
            turn_q          <= 1'b0;
            sr.busy         <= 1'b0;
            sr.result_valid <= 1'b0;
            sr.result       <= 2'b00;
            player_hits     <= '0;
            pc_hits         <= '0;
            game_over       <= 1'b0;
            winner          <= 1'b0;
            shots_on_pc     <= '0;
            shots_on_player <= '0;
        end else if (sr.new_game) begin
            state           <= IDLE;
            req             <= '0;
            turn_q          <= 1'b0;
            sr.busy         <= 1'b0;
            sr.result_valid <= 1'b0;
            sr.result       <= 2'b00;
            player_hits     <= '0;
            pc_hits         <= '0;
            game_over       <= 1'b0;
            winner          <= 1'b0;
            shots_on_pc     <= '0;
            shots_on_player <= '0;
        end else begin
            sr.result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sr.fire && sr.attack_State && !game_over) begin
                        req     <= {shooter, sr.i_target, sr.j_target};
`ifndef SHOT_RESOLVER_TURN_AUTO_EN
                        turn_q  <= sr.turn;
`endif
                        sr.busy <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    sr.result       <= code;
                    sr.result_valid <= 1'b1;
                    sr.busy         <= 1'b0;
                    state           <= RESOLVE;
                    if (code == HIT || code == MISS) begin
                        if (req.side) shots_on_player[req.i][req.j] <= 1'b1;
                        else          shots_on_pc[req.i][req.j]     <= 1'b1;
                    end
                    if (code == HIT) begin
                        if (req.side) pc_hits     <= cnt_nxt;
                        else          player_hits <= cnt_nxt;
                        if (cnt_nxt == total_ship_cells && total_ship_cells != '0) begin
                            game_over <= 1'b1;
                            winner    <= req.side;
                        end
                    end
`ifdef SHOT_RESOLVER_TURN_AUTO_EN
                    if (code == MISS) turn_q <= ~turn_q;
`endif
                end
                RESOLVE: state <= game_over ? OVER : IDLE;
                OVER:    state <= OVER;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: vector table, corner sequences, random shots vs. a rule model.
module tb_shot_resolver;
  localparam int N = 5;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shot_resolver_if sr();
  logic [CNT_W-1:0]         total_ship_cells, player_hits, pc_hits;
  logic [N-1:0][N-1:0][1:0] tablero_jugador, tablero_pc;
  logic                     game_over, winner, turn_out;
  logic [N-1:0][N-1:0]      shots_on_pc, shots_on_player;

  shot_resolver #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sr(sr),
    .total_ship_cells(total_ship_cells),
    .tablero_jugador(tablero_jugador), .tablero_pc(tablero_pc),
    .player_hits(player_hits), .pc_hits(pc_hits),
    .game_over(game_over), .winner(winner), .turn_out(turn_out),
    .shots_on_pc(shots_on_pc), .shots_on_player(shots_on_player)
  );

  // model: index 0 = shots by the player on the PC board, 1 = shots by the PC on the player board
  logic [1:0] m_brd [2][N][N];
  bit         m_map [2][N][N];
  int         m_cnt [2];
  bit         m_go, m_win, m_turn;
  int         checks = 0, failures = 0;

  typedef struct {
    bit         t;
    int         i;
    int         j;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_map[s][i][j] = 1'b0;
    end
    m_go = 0; m_win = 0; m_turn = 0;
  endtask

  task automatic apply_boards();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tablero_pc[i][j]      = m_brd[0][i][j];
        tablero_jugador[i][j] = m_brd[1][i][j];
      end
  endtask

  task automatic clear_boards();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_brd[s][i][j] = 2'b00;
  endtask

  function automatic logic [N-1:0][N-1:0] map_of(input int s);
    logic [N-1:0][N-1:0] m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = m_map[s][i][j];
    return m;
  endfunction

  // shooter of an accepted shot (updates the model's turn bookkeeping)
  function automatic int side_for(input bit t);
`ifdef SHOT_RESOLVER_TURN_AUTO_EN
    return int'(m_turn);
`else
    m_turn = t;
    return int'(t);
`endif
  endfunction

  function automatic logic [1:0] m_shoot(input int s, input int i, input int j);
    logic [1:0] c;
    if (i >= N || j >= N) c = 2'b11;
    else if (m_map[s][i][j]) c = 2'b10;
    else begin
      m_map[s][i][j] = 1'b1;
      if (m_brd[s][i][j] == 2'b01) begin
        c = 2'b01;
        if (m_cnt[s] < (1 << CNT_W) - 1) m_cnt[s]++;
        if (total_ship_cells != 0 && m_cnt[s] == int'(total_ship_cells)) begin
          m_go = 1; m_win = s[0];
        end
      end else c = 2'b00;
    end
`ifdef SHOT_RESOLVER_TURN_AUTO_EN
    if (c == 2'b00) m_turn = !m_turn;
`endif
    return c;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".player_hits"}, player_hits, m_cnt[0]);
    chk({tag, ".pc_hits"}, pc_hits, m_cnt[1]);
    chk({tag, ".game_over"}, game_over, m_go);
    chk({tag, ".winner"}, winner, m_win);
    chk({tag, ".turn_out"}, turn_out, m_turn);
    chk({tag, ".shots_on_pc"}, shots_on_pc, map_of(0));
    chk({tag, ".shots_on_player"}, shots_on_player, map_of(1));
    chk({tag, ".busy"}, sr.busy, 1'b0);
  endtask

  // one fire pulse; checks acceptance, latency 2, single pulse, code and resulting state
  task automatic shot(input bit t, input int i, input int j, input bit atk, input string tag,
                      output logic [1:0] got);
    bit acc;
    int lat, nv;
    logic [1:0] exp_c;
    exp_c = 2'b00; got = 2'b00; lat = 0; nv = 0;
    @(posedge clk); #1;
    acc = atk && !m_go;
    sr.fire = 1'b1; sr.turn = t; sr.attack_State = atk;
    sr.i_target = 3'(i); sr.j_target = 3'(j);
    if (acc) exp_c = m_shoot(side_for(t), i, j);
    @(posedge clk); #1;
    sr.fire = 1'b0; sr.attack_State = 1'b1;
    chk({tag, ".busy_on_accept"}, sr.busy, acc);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (sr.result_valid) begin
        nv++;
        if (lat == 0) begin lat = k; got = sr.result; end
      end
    end
    chk({tag, ".pulses"}, nv, acc ? 1 : 0);
    if (acc) begin
      chk({tag, ".latency"}, lat, 2);
      chk({tag, ".result"}, got, exp_c);
    end
    check_state(tag);
  endtask

  task automatic new_game_pulse();
    @(posedge clk); #1 sr.new_game = 1'b1;
    @(posedge clk); #1 sr.new_game = 1'b0;
    m_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] got;
    int nv;
    tbl[0]  = '{1'b1, 0, 0, 2'b00};
    tbl[1]  = '{1'b1, 0, 0, 2'b10};
    tbl[2]  = '{1'b0, 5, 1, 2'b11};
    tbl[3]  = '{1'b0, 1, 7, 2'b11};
    tbl[4]  = '{1'b0, 0, 0, 2'b01};
    tbl[5]  = '{1'b0, 0, 0, 2'b10};
    tbl[6]  = '{1'b1, 2, 2, 2'b01};
    tbl[7]  = '{1'b0, 4, 4, 2'b01};
    tbl[8]  = '{1'b0, 0, 1, 2'b00};
    tbl[9]  = '{1'b1, 4, 4, 2'b00};
    tbl[10] = '{1'b0, 1, 1, 2'b01};

    rst = 1'b0;
    sr.attack_State = 1'b1; sr.new_game = 1'b0; sr.fire = 1'b0; sr.turn = 1'b0;
    sr.i_target = 3'd0; sr.j_target = 3'd0;
    total_ship_cells = 5'd1;
    clear_boards(); apply_boards(); m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset.result_valid", sr.result_valid, 1'b0);
    chk("reset.result", sr.result, 2'b00);
    rst = 1'b1;

    // single-ship board: one hit ends the game, further fires ignored
    m_brd[0][2][3] = 2'b01; apply_boards();
    shot(1'b0, 2, 3, 1'b1, "first_hit", got);
    chk("first_hit.code", got, 2'b01);
    chk("first_hit.game_over", game_over, 1'b1);
    shot(1'b0, 1, 1, 1'b1, "over_fire", got);
    new_game_pulse();
    check_state("new_game1");

    clear_boards();
    m_brd[0][0][0] = 2'b01; m_brd[0][1][1] = 2'b01; m_brd[0][4][4] = 2'b01;
    m_brd[1][2][2] = 2'b01; m_brd[1][3][0] = 2'b01; m_brd[1][0][4] = 2'b01;
    m_brd[1][4][4] = 2'b10; m_brd[0][0][1] = 2'b11;
    apply_boards();
    total_ship_cells = 5'd3;
    for (int k = 0; k < 11; k++) begin
      shot(tbl[k].t, tbl[k].i, tbl[k].j, 1'b1, "table", got);
`ifndef SHOT_RESOLVER_TURN_AUTO_EN
      chk("table.code", got, tbl[k].exp);
`endif
    end
    new_game_pulse();
    check_state("new_game2");

    shot(1'b0, 0, 0, 1'b0, "no_attack", got);

    // second fire while busy is ignored
    @(posedge clk); #1;
    sr.fire = 1'b1; sr.turn = 1'b1; sr.i_target = 3'd2; sr.j_target = 3'd2;
    begin
      int s;
      logic [1:0] e;
      s = side_for(1'b1);
      e = m_shoot(s, 2, 2);
      @(posedge clk); #1;
      sr.turn = 1'b0; sr.i_target = 3'd0; sr.j_target = 3'd0;
      @(posedge clk); #1 sr.fire = 1'b0;
      nv = 0; got = 2'b00;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (sr.result_valid) begin nv++; got = sr.result; end
      end
      chk("double_fire.pulses", nv, 1);
      chk("double_fire.result", got, e);
      check_state("double_fire");
    end

    // new_game during CHECK discards the pending shot
    @(posedge clk); #1;
    sr.fire = 1'b1; sr.turn = 1'b0; sr.i_target = 3'd4; sr.j_target = 3'd4;
    @(posedge clk); #1;
    sr.fire = 1'b0; sr.new_game = 1'b1;
    chk("ng_check.busy", sr.busy, 1'b1);
    @(posedge clk); #1 sr.new_game = 1'b0;
    m_reset();
    nv = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (sr.result_valid) nv++; end
    chk("ng_check.pulses", nv, 0);
    check_state("ng_check");

    // asynchronous reset mid-shot
    shot(1'b0, 0, 0, 1'b1, "pre_rst", got);
    @(posedge clk); #1;
    sr.fire = 1'b1; sr.turn = 1'b0; sr.i_target = 3'd1; sr.j_target = 3'd1;
    @(posedge clk); #1;
    sr.fire = 1'b0;
    chk("rst_mid.busy_before", sr.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    m_reset();
    check_state("rst_mid");
    chk("rst_mid.result", sr.result, 2'b00);
    @(posedge clk); #1 rst = 1'b1;
    nv = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (sr.result_valid) nv++; end
    chk("rst_mid.pulses", nv, 0);

    // random boards and shots against the model
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_brd[s][i][j] = 2'($urandom % 4);
    apply_boards();
    total_ship_cells = 5'($urandom_range(1, 4));
    for (int n = 0; n < 80; n++) begin
      shot(1'($urandom % 2), $urandom_range(0, 5), $urandom_range(0, 5),
           ($urandom % 8) != 0, "random", got);
      if (m_go && ($urandom % 3) == 0) begin
        new_game_pulse();
        for (int s = 0; s < 2; s++)
          for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_brd[s][i][j] = 2'($urandom % 4);
        apply_boards();
        total_ship_cells = 5'($urandom_range(1, 4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shot_resolver.md
Name: shot_resolver

Overview:
- Attack-phase stage directly downstream of the board-setup block.
- Consumes the finished player and PC boards (2-bit cells, 5x5) and resolves one shot per request against the selected board.
- Keeps per-board shot maps and hit counters, and declares game over and the winner.
- Feeds the VGA controller (shot maps, last result) and the game FSM (busy, game_over).

Parameters:
- N, 5: board dimension; valid coordinates are 0..N-1.
- CNT_W, 5: width of hit counters and ship-cell totals.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- attack_State  in  1  game FSM is in attack phase; shots are accepted only while high.
- new_game  in  1  synchronous clear of maps, counters and game_over.
- fire  in  1  single-cycle shot request.
- turn  in  1  0 = player fires at PC board; 1 = PC fires at player board.
- i_target  in  3  target row.
- j_target  in  3  target column.
- total_ship_cells  in  CNT_W  ship cells per side; stable during attack.
- tablero_jugador  in  2x[N][N]  player board; BARCO = 2'b01.
- tablero_pc  in  2x[N][N]  PC board.
- busy  out  1  high from fire acceptance until the result is issued.
- result_valid  out  1  one-cycle pulse.
- result  out  2  00 MISS, 01 HIT, 10 REPEAT, 11 INVALID.
- player_hits  out  CNT_W  hits scored by the player on the PC board.
- pc_hits  out  CNT_W  hits scored by the PC on the player board.
- game_over  out  1  sticky until rst or new_game.
- winner  out  1  0 = player, 1 = PC; valid when game_over.
- turn_out  out  1  side whose shot is currently pending or next.
- shots_on_pc  out  1x[N][N]  cells of the PC board already fired on.
- shots_on_player  out  1x[N][N]  cells of the player board already fired on.

Behaviour:
- Reset values: all maps 0, counters 0, busy 0, result_valid 0, result 00, game_over 0, winner 0, turn_out 0, FSM in IDLE.
- FSM states: IDLE, CHECK, RESOLVE, OVER.
- IDLE:
  - fire && attack_State && !game_over: latch i_target, j_target and turn; busy <= 1; go to CHECK.
  - fire is ignored otherwise, and while busy.
- CHECK:
  - Either coordinate >= N: code INVALID.
  - Otherwise, target shot-map bit already set: code REPEAT.
  - Otherwise, target board cell == BARCO: code HIT.
  - Otherwise: code MISS.
  - Always go to RESOLVE.
- RESOLVE:
  - result <= code; result_valid <= 1 for this cycle only; busy <= 0.
  - HIT or MISS: set the target shot-map bit.
  - HIT: increment the shooter's counter.
  - If the incremented counter == total_ship_cells and total_ship_cells != 0: game_over <= 1, winner <= shooter, go to OVER. Otherwise go to IDLE.
- Latency: fire accepted at cycle T; result_valid at T+2. The next fire is accepted from T+3.
- INVALID and REPEAT change no maps or counters.
- Counters saturate at 2^CNT_W-1; they never wrap.
- OVER: fire is ignored and all outputs hold. Only rst or new_game leaves OVER.
- new_game has priority over everything except rst. It returns the block to its reset values in one cycle, from any state, including mid-shot; a pending result is discarded and no result_valid is issued.
- attack_State dropping mid-shot does not abort the shot; the result is still issued.
- Board inputs are sampled in CHECK only.

Optional Feature:
- Macro: SHOT_RESOLVER_TURN_AUTO_EN.
- Defined:
  - The turn port is ignored; an internal turn register drives turn_out.
  - Reset and new_game set the register to 0 (player first).
  - In RESOLVE it toggles on MISS and is unchanged on HIT, REPEAT or INVALID.
  - The latched shooter is the register value at fire acceptance.
- Undefined: turn_out = turn latched at the last accepted fire (0 after reset).

Test Plan:
- Reset, then PC board with BARCO at (2,3), total_ship_cells=1, turn=0, fire at (2,3) -> result_valid at T+2, result=01, player_hits=1, shots_on_pc[2][3]=1, game_over=1, winner=0.
- turn=1, fire at (0,0) on water -> result=00, pc_hits=0, shots_on_player[0][0]=1; repeat the same fire -> result=10, maps and counters unchanged.
- fire at (5,1) -> result=11, no state change; fire with attack_State=0 -> no busy, no result_valid.
- Second fire pulse at T+1 while busy -> ignored, exactly one result_valid; in OVER, fire ignored; new_game -> counters, maps and game_over all cleared.
- Assert new_game in the CHECK cycle -> no result_valid, everything cleared; assert rst low mid-shot -> immediate reset values.
- With SHOT_RESOLVER_TURN_AUTO_EN: MISS -> turn_out goes 0 to 1; PC HIT -> stays 1; next MISS -> returns to 0; the turn port has no effect.
